// File: rtl/data_mem_arbiter_if.sv
// Bundle of requester-side and RAM-side signals for the data RAM arbiter.
interface data_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_vld;

  logic              img_req;
  logic              img_wr;
  logic [ADDR_W-1:0] img_addr;
  logic [DATA_W-1:0] img_wdata;
  logic [DATA_W-1:0] img_rdata;
  logic              img_vld;

  logic              spart_req;
  logic [ADDR_W-1:0] spart_addr;
  logic [DATA_W-1:0] spart_rdata;
  logic              spart_vld;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [1:0]        grant_id;

  // Arbiter view
  modport slave (
    input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_vld,
    input  img_req, img_wr, img_addr, img_wdata,
    output img_rdata, img_vld,
    input  spart_req, spart_addr,
    output spart_rdata, spart_vld,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata,
    output grant_id
  );

  // Requester / RAM environment view
  modport master (
    output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_vld,
    output img_req, img_wr, img_addr, img_wdata,
    input  img_rdata, img_vld,
    output spart_req, spart_addr,
    input  spart_rdata, spart_vld,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata,
    input  grant_id
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing the single-ported data RAM between CPU, image
// processor and SPART; one transaction at a time, fixed RAM read latency.
module data_mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1   // must be >= 1
) (
  input logic               clk,
  input logic               rst_n,
  data_mem_arbiter_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        last_grant;
  logic [1:0]        grant_q;
  logic              cur_wr;
  logic              ram_en_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] img_rdata_q;
  logic [DATA_W-1:0] spart_rdata_q;
  logic              cpu_vld_q;
  logic              img_vld_q;
  logic              spart_vld_q;

  logic              any_req;
  logic [1:0]        win;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Round-robin winner: search starts one past the last grant
  always_comb begin
    any_req = bus.cpu_req | bus.img_req | bus.spart_req;
    win     = 2'd0;
    case (last_grant)
      2'd0: begin
        if (bus.img_req)        win = 2'd1;
        else if (bus.spart_req) win = 2'd2;
        else                    win = 2'd0;
      end
      2'd1: begin
        if (bus.spart_req)      win = 2'd2;
        else if (bus.cpu_req)   win = 2'd0;
        else                    win = 2'd1;
      end
      default: begin
        if (bus.cpu_req)        win = 2'd0;
        else if (bus.img_req)   win = 2'd1;
        else                    win = 2'd2;
      end
    endcase
  end

  // Winner's transaction fields; SPART is read-only and keeps the last wdata
  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = bus.spart_addr;
    sel_wdata = wdata_q;
    case (win)
      2'd0: begin
        sel_wr    = bus.cpu_wr;
        sel_addr  = bus.cpu_addr;
        sel_wdata = bus.cpu_wdata;
      end
      2'd1: begin
        sel_wr    = bus.img_wr;
        sel_addr  = bus.img_addr;
        sel_wdata = bus.img_wdata;
      end
      default: ;
    endcase
  end

  // Transaction sequencer with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      last_grant    <= 2'd2;
      grant_q       <= '0;
      cur_wr        <= 1'b0;
      ram_en_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      cpu_rdata_q   <= '0;
      img_rdata_q   <= '0;
      spart_rdata_q <= '0;
      cpu_vld_q     <= 1'b0;
      img_vld_q     <= 1'b0;
      spart_vld_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state      <= ISSUE;
            grant_q    <= win;
            last_grant <= win;
            cur_wr     <= sel_wr;
            ram_en_q   <= 1'b1;
            ram_we_q   <= sel_wr;
            addr_q     <= sel_addr;
            wdata_q    <= sel_wdata;
          end
        end
        ISSUE: begin
          ram_en_q <= 1'b0;
          ram_we_q <= 1'b0;
          cnt      <= CNT_W'(RD_LAT);
          state    <= WAIT;
        end
        WAIT: begin
          if (cnt == CNT_W'(1)) begin
            state <= DONE;
            case (grant_q)
              2'd0: begin
                cpu_vld_q <= 1'b1;
                if (!cur_wr) cpu_rdata_q <= bus.ram_rdata;
              end
              2'd1: begin
                img_vld_q <= 1'b1;
                if (!cur_wr) img_rdata_q <= bus.ram_rdata;
              end
              default: begin
                spart_vld_q   <= 1'b1;
                spart_rdata_q <= bus.ram_rdata;
              end
            endcase
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          cpu_vld_q   <= 1'b0;
          img_vld_q   <= 1'b0;
          spart_vld_q <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ram_en      = ram_en_q;
  assign bus.ram_we      = ram_we_q;
  assign bus.ram_addr    = addr_q;
  assign bus.ram_wdata   = wdata_q;
  assign bus.grant_id    = grant_q;
  assign bus.cpu_rdata   = cpu_rdata_q;
  assign bus.cpu_vld     = cpu_vld_q;
  assign bus.img_rdata   = img_rdata_q;
  assign bus.img_vld     = img_vld_q;
  assign bus.spart_rdata = spart_rdata_q;
  assign bus.spart_vld   = spart_vld_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench: two arbiters (RD_LAT=1 and RD_LAT=3) with simple RAM models.
module tb_data_mem_arbiter;
  localparam logic [31:0] BAD = 32'hBAD0_0BAD;

  typedef struct {
    int          dut;
    int          id;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  data_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1();
  data_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3();

  data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );
  data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(b3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM models: latency 1 for b1, latency 3 for b3; junk when no read is due
  logic [31:0] mem1 [0:255];
  logic [31:0] mem3 [0:255];
  logic [31:0] p0, p1;
  bit          ram_init = 1'b0;

  always @(posedge clk) begin
    if (!ram_init) begin
      mem1[8'h10] <= 32'hDEAD_BEEF;
      mem1[8'h30] <= 32'h0000_1234;
      mem3[8'h40] <= 32'hCAFE_0003;
      mem3[8'h50] <= 32'h55AA_55AA;
      ram_init    <= 1'b1;
    end else begin
      if (b1.ram_en && b1.ram_we) mem1[b1.ram_addr[7:0]] <= b1.ram_wdata;
      if (b3.ram_en && b3.ram_we) mem3[b3.ram_addr[7:0]] <= b3.ram_wdata;
    end
    b1.ram_rdata <= (b1.ram_en && !b1.ram_we) ? mem1[b1.ram_addr[7:0]] : BAD;
    p0           <= (b3.ram_en && !b3.ram_we) ? mem3[b3.ram_addr[7:0]] : BAD;
    p1           <= p0;
    b3.ram_rdata <= p1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_vld(input int d, input int id, input logic [31:0] data, input int c);
    exp_t e;
    e.dut  = d;
    e.id   = id;
    e.data = data;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic observe(input int d, input int id, input logic [31:0] data);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_vld: dut%0d id%0d data %h cycle %0d, none expected", d, id, data, cyc);
    end else begin
      e = sb.pop_front();
      if (e.dut != d || e.id != id || e.data !== data || e.cyc != cyc) begin
        errors++;
        $display("FAIL vld_response: got dut%0d id%0d data %h cycle %0d, expected dut%0d id%0d data %h cycle %0d",
                 d, id, data, cyc, e.dut, e.id, e.data, e.cyc);
      end
    end
  endtask

  // Monitor: every valid pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (b1.cpu_vld)   observe(1, 0, b1.cpu_rdata);
    if (b1.img_vld)   observe(1, 1, b1.img_rdata);
    if (b1.spart_vld) observe(1, 2, b1.spart_rdata);
    if (b3.cpu_vld)   observe(3, 0, b3.cpu_rdata);
    if (b3.img_vld)   observe(3, 1, b3.img_rdata);
    if (b3.spart_vld) observe(3, 2, b3.spart_rdata);
  end

  task automatic to_cycle(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst_n = 1'b0;
    b1.cpu_req = 1'b0; b1.cpu_wr = 1'b0; b1.cpu_addr = '0; b1.cpu_wdata = '0;
    b1.img_req = 1'b0; b1.img_wr = 1'b0; b1.img_addr = '0; b1.img_wdata = '0;
    b1.spart_req = 1'b0; b1.spart_addr = '0;
    b3.cpu_req = 1'b0; b3.cpu_wr = 1'b0; b3.cpu_addr = '0; b3.cpu_wdata = '0;
    b3.img_req = 1'b0; b3.img_wr = 1'b0; b3.img_addr = '0; b3.img_wdata = '0;
    b3.spart_req = 1'b0; b3.spart_addr = '0;

    // Reset values
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_grant_id", b1.grant_id, 2'd0);
    chk("rst_ram_en", b1.ram_en, 1'b0);
    chk("rst_ram_addr", b1.ram_addr, 32'h0);
    chk("rst_cpu_rdata", b1.cpu_rdata, 32'h0);
    chk("rst_vld", {b1.cpu_vld, b1.img_vld, b1.spart_vld}, 3'b000);
    chk("rst_dut3_ram_we", b3.ram_we, 1'b0);
    to_cycle(3);
    rst_n = 1'b1;

    // Single CPU read of 0x10
    to_cycle(5);
    t = cyc;
    b1.cpu_req = 1'b1; b1.cpu_wr = 1'b0; b1.cpu_addr = 32'h10;
    expect_vld(1, 0, 32'hDEAD_BEEF, t + 3);
    to_cycle(t + 1); @(negedge clk);
    chk("t1_ram_en", b1.ram_en, 1'b1);
    chk("t1_ram_we", b1.ram_we, 1'b0);
    chk("t1_ram_addr", b1.ram_addr, 32'h10);
    chk("t1_grant_id", b1.grant_id, 2'd0);
    to_cycle(t + 4);
    b1.cpu_req = 1'b0;

    // IMG write 0xA5 to 0x20, then SPART read of 0x20
    to_cycle(t + 6);
    t = cyc;
    b1.img_req = 1'b1; b1.img_wr = 1'b1; b1.img_addr = 32'h20; b1.img_wdata = 32'hA5;
    expect_vld(1, 1, 32'h0, t + 3);
    to_cycle(t + 1); @(negedge clk);
    chk("t2_ram_we", b1.ram_we, 1'b1);
    chk("t2_ram_wdata", b1.ram_wdata, 32'hA5);
    chk("t2_grant_id", b1.grant_id, 2'd1);
    to_cycle(t + 2); @(negedge clk);
    chk("t2_ram_en_off", b1.ram_en, 1'b0);
    chk("t2_ram_addr_hold", b1.ram_addr, 32'h20);
    to_cycle(t + 4);
    b1.img_req = 1'b0;
    b1.spart_req = 1'b1; b1.spart_addr = 32'h20;
    expect_vld(1, 2, 32'hA5, t + 7);
    to_cycle(t + 5); @(negedge clk);
    chk("t2_spart_grant", b1.grant_id, 2'd2);
    to_cycle(t + 8);
    b1.spart_req = 1'b0;
    @(negedge clk);
    chk("t2_img_rdata_kept", b1.img_rdata, 32'h0);
    chk("t2_grant_hold", b1.grant_id, 2'd2);

    // CPU read of 0x30, then IMG read; cpu_rdata must hold
    to_cycle(t + 10);
    t = cyc;
    b1.cpu_req = 1'b1; b1.cpu_wr = 1'b0; b1.cpu_addr = 32'h30;
    expect_vld(1, 0, 32'h0000_1234, t + 3);
    to_cycle(t + 4);
    b1.cpu_req = 1'b0;
    b1.img_req = 1'b1; b1.img_wr = 1'b0; b1.img_addr = 32'h20;
    expect_vld(1, 1, 32'hA5, t + 7);
    to_cycle(t + 8);
    b1.img_req = 1'b0;
    @(negedge clk);
    chk("t6_cpu_rdata_held", b1.cpu_rdata, 32'h0000_1234);

    // RD_LAT=3 CPU read: vld in c5, no extra ram_en while busy
    to_cycle(t + 10);
    t = cyc;
    b3.cpu_req = 1'b1; b3.cpu_wr = 1'b0; b3.cpu_addr = 32'h40;
    expect_vld(3, 0, 32'hCAFE_0003, t + 5);
    to_cycle(t + 1); @(negedge clk);
    chk("t4_ram_en", b3.ram_en, 1'b1);
    chk("t4_ram_addr", b3.ram_addr, 32'h40);
    for (int k = 2; k <= 5; k++) begin
      to_cycle(t + k); @(negedge clk);
      chk("t4_busy_no_en", b3.ram_en, 1'b0);
    end
    to_cycle(t + 6);
    b3.cpu_req = 1'b0;

    // Reset during WAIT of an IMG read on RD_LAT=3, CPU held across reset
    to_cycle(t + 8);
    t = cyc;
    b3.img_req = 1'b1; b3.img_wr = 1'b0; b3.img_addr = 32'h50;
    to_cycle(t + 1); @(negedge clk);
    chk("t5_img_grant", b3.grant_id, 2'd1);
    to_cycle(t + 2);
    b3.cpu_req = 1'b1; b3.cpu_wr = 1'b0; b3.cpu_addr = 32'h40;
    to_cycle(t + 3);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_grant_id", b3.grant_id, 2'd0);
    chk("t5_rst_cpu_rdata", b3.cpu_rdata, 32'h0);
    chk("t5_rst_ram_addr", b3.ram_addr, 32'h0);
    chk("t5_rst_img_vld", b3.img_vld, 1'b0);
    chk("t5_rst_dut1_img_rdata", b1.img_rdata, 32'h0);
    b3.img_req = 1'b0;
    to_cycle(t + 5);
    rst_n = 1'b1;
    expect_vld(3, 0, 32'hCAFE_0003, t + 10);
    to_cycle(t + 6); @(negedge clk);
    chk("t5_cpu_first", b3.grant_id, 2'd0);
    chk("t5_cpu_ram_en", b3.ram_en, 1'b1);
    to_cycle(t + 11);
    b3.cpu_req = 1'b0;

    // All three requesters held after reset: cpu, img, spart, cpu
    to_cycle(t + 13);
    t = cyc;
    b1.cpu_req = 1'b1;   b1.cpu_wr = 1'b0; b1.cpu_addr = 32'h10;
    b1.img_req = 1'b1;   b1.img_wr = 1'b0; b1.img_addr = 32'h20;
    b1.spart_req = 1'b1; b1.spart_addr = 32'h30;
    expect_vld(1, 0, 32'hDEAD_BEEF, t + 3);
    expect_vld(1, 1, 32'hA5, t + 7);
    expect_vld(1, 2, 32'h0000_1234, t + 11);
    expect_vld(1, 0, 32'hDEAD_BEEF, t + 15);
    to_cycle(t + 5); @(negedge clk);
    chk("t3_grant_img", b1.grant_id, 2'd1);
    to_cycle(t + 9); @(negedge clk);
    chk("t3_grant_spart", b1.grant_id, 2'd2);
    to_cycle(t + 13); @(negedge clk);
    chk("t3_grant_cpu_again", b1.grant_id, 2'd0);
    to_cycle(t + 16);
    b1.cpu_req = 1'b0; b1.img_req = 1'b0; b1.spart_req = 1'b0;

    to_cycle(t + 22); @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
